vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 H_DISPLAY, 640, visible pixels per line.
REQ-002 H_FRONT, 16, horizontal front porch in pixels.
REQ-003 H_SYNC, 96, hsync pulse width in pixels.
REQ-004 H_BACK, 48, horizontal back porch in pixels.
REQ-005 V_DISPLAY, 480, visible lines per frame.
REQ-006 V_FRONT, 10, vertical front porch in lines.
REQ-007 V_SYNC, 2, vsync pulse width in lines.
REQ-008 V_BACK, 33, vertical back porch in lines.
REQ-009 PIX_DIV, 4, clk_100MHz cycles per pixel (25 MHz pixel rate).
REQ-010 clk_100MHz  input  1  system clock, 100 MHz; all state on rising edge.
REQ-011 reset  input  1  reset, asynchronous, active-high.
REQ-012 rgb_in  input  12  pixel colour from the pixel generator for the current x, y.
REQ-013 p_tick  output  1  one-clock pulse marking each pixel period.
REQ-014 x  output  10  current horizontal count, 0..799.
REQ-015 y  output  10  current vertical count, 0..524.
REQ-016 in_display_area  output  1  high when x < H_DISPLAY and y < V_DISPLAY.
REQ-017 hsync  output  1  horizontal sync, active-low, pipeline-aligned with rgb_out.
REQ-018 vsync  output  1  vertical sync, active-low, pipeline-aligned with rgb_out.
REQ-019 rgb_out  output  12  registered colour to the DAC.
REQ-020 frame_start  output  1  one-clock pulse when x and y both wrap to 0.

Function
REQ-021 Divider counts 0..PIX_DIV-1 every clock and wraps; p_tick is high for exactly one clock, when the divider equals PIX_DIV-1.
REQ-022 x increments only on p_tick; at H_TOTAL-1 (799) it wraps to 0, where H_TOTAL = sum of the four H parameters.
REQ-023 y increments only on a p_tick on which x wraps; at V_TOTAL-1 (524) it wraps to 0, where V_TOTAL = sum of the four V parameters.
REQ-024 x, y and in_display_area are registered and change only on the clock following p_tick.
REQ-025 Stage-1 sync: hsync_s1 low iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751); vsync_s1 low iff 490 <= y < 492.
REQ-026 Stage 2 registers on p_tick: rgb_out <= rgb_in when in_display_area, else 12'h000; hsync <= hsync_s1; vsync <= vsync_s1.
REQ-027 Latency from x/y/rgb_in to rgb_out/hsync/vsync is exactly one pixel period (PIX_DIV clocks).
REQ-028 rgb_out is 12'h000 whenever the aligned sample was outside the display area, regardless of rgb_in.
REQ-029 frame_start is high for one clock on the p_tick on which x = 799 and y = 524.
REQ-030 Counter arithmetic is 10-bit unsigned; no count exceeds H_TOTAL-1 or V_TOTAL-1.
REQ-031 The sync line boundary is decoded from the registered counter value, so it produces no glitch on the wrap clock.

Reset
REQ-032 While reset is high, divider, x and y are 0, and p_tick, frame_start and rgb_out are 0.
REQ-033 While reset is high, hsync and vsync are 1 (inactive).
REQ-034 A reset asserted mid-line or mid-frame aborts immediately. After release, the first p_tick occurs PIX_DIV clocks later and counting restarts from x = 0, y = 0.

Configuration
REQ-035 With VGA_SYNC_FRAME_CNT_EN defined, the block adds output frame_count (16 bits), which resets to 0, increments on each frame_start, and wraps from 16'hFFFF to 0.
REQ-036 Without VGA_SYNC_FRAME_CNT_EN, the frame_count port and its logic are absent, and all other behaviour is identical.

Verification
REQ-037 Release reset, then run 8 clocks -> p_tick is high at clocks 4 and 8 only, and x = 1 after the first tick.
REQ-038 Run one line -> hsync is low for exactly 96 p_ticks, starting one pixel after x = 656; x wraps 799 -> 0 and y increments to 1.
REQ-039 Run one frame -> vsync is low for exactly 2 lines (y 490..491, delayed one pixel), and frame_start pulses once at x = 799, y = 524.
REQ-040 Drive rgb_in = 12'h0F0 constantly -> rgb_out = 12'h0F0 for the 640x480 area, one pixel late, and 12'h000 elsewhere.
REQ-041 Assert reset at x = 300, y = 200 for 3 clocks -> all outputs take their reset values at once, and restart from 0,0 after release.
REQ-042 With VGA_SYNC_FRAME_CNT_EN defined, run 3 frames -> frame_count = 3.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator with a one-pixel registered output stage.
// Define VGA_SYNC_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_DIV   = 4
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [11:0] rgb_in,
  output logic        p_tick,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        in_display_area,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out,
  output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DW-1:0] div;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          x_wrap;
  logic          y_wrap;
  logic          hsync_s1;
  logic          vsync_s1;

  assign p_tick      = (div == DIV_LAST);
  assign x_wrap      = (x == X_LAST);
  assign y_wrap      = (y == Y_LAST);
  assign frame_start = p_tick & x_wrap & y_wrap;

  always_comb begin
    x_next = x + 10'd1;
    y_next = y;
    if (x_wrap) begin
      x_next = '0;
      y_next = y_wrap ? '0 : y + 10'd1;
    end
  end

  // Decoded from registered counters so the wrap clock cannot glitch them
  assign hsync_s1 = !((x >= HS_BEG) && (x < HS_END));
  assign vsync_s1 = !((y >= VS_BEG) && (y < VS_END));

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (p_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      x               <= '0;
      y               <= '0;
      in_display_area <= 1'b1;
    end else if (p_tick) begin
      x               <= x_next;
      y               <= y_next;
      in_display_area <= (x_next < X_VIS) && (y_next < Y_VIS);
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rgb_out <= 12'h000;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else if (p_tick) begin
      rgb_out <= in_display_area ? rgb_in : 12'h000;
      hsync   <= hsync_s1;
      vsync   <= vsync_s1;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_start) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a shrunken 16x9 raster so whole frames
// fit in a short run; directed counts plus a per-clock reference model.
module tb_vga_sync_gen;

  localparam int HD = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VD = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int PD = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] rgb_in = 12'h0F0;
  logic        p_tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        in_display_area;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb_out;
  logic        frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  int checks = 0;
  int passed = 0;

  int mdiv, mx, my;
  logic mhs, mvs;
  logic [11:0] mrgb;
  int nfs, nhs, nvs, ngrn;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(PD)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .rgb_in(rgb_in),
    .p_tick(p_tick),
    .x(x),
    .y(y),
    .in_display_area(in_display_area),
    .hsync(hsync),
    .vsync(vsync),
    .rgb_out(rgb_out),
    .frame_start(frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [36:0] obs_vec();
    return {p_tick, x, y, in_display_area, hsync, vsync,
            rgb_out, frame_start};
  endfunction

  function automatic logic [36:0] exp_vec();
    logic ptk, ide, fs;
    ptk = (mdiv == PD - 1);
    ide = (mx < HD) && (my < VD);
    fs  = ptk && (mx == HT - 1) && (my == VT - 1);
    return {ptk, 10'(mx), 10'(my), ide, mhs, mvs, mrgb, fs};
  endfunction

  task automatic model_reset();
    mdiv = 0; mx = 0; my = 0;
    mhs = 1'b1; mvs = 1'b1; mrgb = 12'h000;
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    if (reset) begin
      model_reset();
    end else if (mdiv == PD - 1) begin
      mrgb = ((mx < HD) && (my < VD)) ? rgb_in : 12'h000;
      mhs  = !((mx >= HD + HF) && (mx < HD + HF + HS));
      mvs  = !((my >= VD + VF) && (my < VD + VF + VS));
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
      mdiv = 0;
    end else begin
      mdiv++;
    end
    #1;
  endtask

  task automatic step_chk(input string tag);
    step();
    check(tag, obs_vec(), exp_vec());
    if (p_tick) begin
      if (!hsync) nhs++;
      if (!vsync) nvs++;
      if (rgb_out == 12'h0F0) ngrn++;
    end
    if (frame_start) nfs++;
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    check("rst_vec", obs_vec(), exp_vec());
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_x", x, 0);

    @(negedge clk_100MHz);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("ptick_seq", p_tick, (c == 4 || c == 8) ? 1 : 0);
      step();
      check("x_seq", x, (c >= 8) ? 2 : ((c >= 4) ? 1 : 0));
    end

    begin
      int i;
      for (i = 0; i < 2000; i++) begin
        if (mx == 12 && my == 5 && mdiv == PD - 1) break;
        step_chk("scan");
      end
      check("reach_mid", (i < 2000) ? 1 : 0, 1);
    end
    check("mid_hsync_low", hsync, 0);
    check("mid_vsync_low", vsync, 0);
    check("mid_ptick", p_tick, 1);

    #2 reset = 1'b1;
    #1 model_reset();
    check("abort_vec", obs_vec(), exp_vec());
    check("abort_hsync", hsync, 1);
    check("abort_vsync", vsync, 1);
    check("abort_x", x, 0);
    check("abort_y", y, 0);
    check("abort_ptick", p_tick, 0);
    repeat (3) step_chk("hold");

    @(negedge clk_100MHz);
    reset = 1'b0;
    nfs = 0; nhs = 0; nvs = 0; ngrn = 0;
    repeat (3 * HT * VT * PD) step_chk("frames");
    check("fs_count", nfs, 3);
    check("hs_low_ticks", nhs, 3 * VT * HS);
    check("vs_low_ticks", nvs, 3 * VS * HT);
    check("green_ticks", ngrn, 3 * HD * VD);
    check("wrap_x", x, 0);
    check("wrap_y", y, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("frame_count", frame_count, 3);
`endif

    for (int i = 0; i < HT * VT * PD; i++) begin
      rgb_in = 12'((mx << 4) | my) ^ 12'hA50;
      step_chk("pattern");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
